// File: rtl/threshold_servo_ctrl_if.sv
// ----------------------------------------------------------------------------
// threshold_servo_ctrl_if
//
// Purpose:
//   Carries the evaluated-sample stream from the threshold servo sequencer
//   to whatever consumes it (logger, host FIFO, LED debug block).
//   Each evaluated DAC code goes out on a plain valid/ready handshake.
//
// Signals:
//   sample_valid  producer -> consumer  a sample is pending
//   sample_ready  consumer -> producer  the consumer takes the sample this cycle
//   sample_code   producer -> consumer  the DAC code that was evaluated
//
// Modports:
//   master  the servo sequencer (drives valid/code, reads ready)
//   slave   the sample consumer (drives ready, reads valid/code)
// ----------------------------------------------------------------------------
interface threshold_servo_ctrl_if #(
    parameter int CODE_BITS = 10
) ();

    logic                 sample_valid;
    logic                 sample_ready;
    logic [CODE_BITS-1:0] sample_code;

    modport master (
        output sample_valid,
        output sample_code,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_code,
        output sample_ready
    );

endinterface

// File: rtl/threshold_servo_ctrl.sv
// ----------------------------------------------------------------------------
// threshold_servo_ctrl
//
// Purpose:
//   Sequencer for the comparator threshold loop (threshold DAC -> LVDS
//   comparator -> window counter). After every DAC code change it waits a
//   settle interval so the window count reflects the new code, then evaluates
//   the count. The operating point is acquired by successive approximation
//   and then tracked by a deadband servo. Every evaluated code is published
//   on a valid/ready sample stream, and locked_o rises once the loop stays
//   inside the deadband for LOCK_COUNT consecutive evaluations.
//
// Build option:
//   SERVO_SAR_EN  when defined, start runs a CODE_BITS-step successive
//                 approximation before tracking. When undefined the SAR
//                 states do not exist and start drops straight into tracking
//                 from mid-scale.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   enable_i     low forces IDLE (checked every cycle)
//   start_i      one-cycle pulse, begins or restarts acquisition
//   target_i     desired window count
//   deadband_i   allowed |count - target| while tracking
//   count_i      window count from the window counter
//   dac_code_o   registered DAC code
//   sample_if    evaluated-sample stream (master side)
//   overrun_o    sticky, a sample was dropped because the consumer stalled
//   locked_o     loop settled inside the deadband
//   state_o      state encoding for debug/LEDs
// ----------------------------------------------------------------------------
module threshold_servo_ctrl #(
    parameter int CODE_BITS     = 10,
    parameter int COUNT_BITS    = 10,
    parameter int SETTLE_CYCLES = 2048,
    parameter int STEP_SHIFT    = 4,
    parameter int LOCK_COUNT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic                      start_i,
    input  logic [COUNT_BITS-1:0]     target_i,
    input  logic [COUNT_BITS-1:0]     deadband_i,
    input  logic [COUNT_BITS-1:0]     count_i,
    output logic [CODE_BITS-1:0]      dac_code_o,
    threshold_servo_ctrl_if.master    sample_if,
    output logic                      overrun_o,
    output logic                      locked_o,
    output logic [2:0]                state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SAR_SETTLE = 3'd1,
        SAR_EVAL   = 3'd2,
        TRK_SETTLE = 3'd3,
        TRK_EVAL   = 3'd4
    } state_t;

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LC_W = $clog2(LOCK_COUNT + 1);
    localparam int SW   = ((CODE_BITS > COUNT_BITS + 1) ? CODE_BITS : COUNT_BITS + 1) + 1;

    localparam logic [SC_W-1:0]       SETTLE_RELOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [SC_W-1:0]       SC_ONE        = 1;
    localparam logic [LC_W-1:0]       LOCK_MAX      = LC_W'(LOCK_COUNT);
    localparam logic [LC_W-1:0]       LC_ONE        = 1;
    localparam logic [CODE_BITS-1:0]  MID_CODE      = {1'b1, {(CODE_BITS-1){1'b0}}};
    localparam logic [CODE_BITS-1:0]  MAX_CODE      = {CODE_BITS{1'b1}};
    localparam logic [COUNT_BITS:0]   ONE_STEP      = 1;

    state_t                 state_q, state_d;
    logic [SC_W-1:0]        settle_q, settle_d;
    logic [CODE_BITS-1:0]   code_q, code_d;
    logic [LC_W-1:0]        lockCnt_q, lockCnt_d;
    logic                   locked_q, locked_d;
    logic                   overrun_q, overrun_d;
    logic                   sampleValid_q, sampleValid_d;
    logic [CODE_BITS-1:0]   sampleCode_q, sampleCode_d;
    logic                   evalFire;
    logic                   sampleLoad;

    logic signed [COUNT_BITS:0] err;
    logic signed [COUNT_BITS:0] dbSigned;
    logic [COUNT_BITS:0]        errMag;
    logic [COUNT_BITS:0]        step;
    logic [SW-1:0]              codeExt;
    logic [SW-1:0]              stepExt;
    logic [SW-1:0]              codeUp;
    logic [SW-1:0]              codeDown;
    logic [CODE_BITS-1:0]       trkUp;
    logic [CODE_BITS-1:0]       trkDown;
    logic                       overBand;
    logic                       underBand;

`ifdef SERVO_SAR_EN
    localparam int TB_W = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;
    localparam logic [TB_W-1:0] TB_MSB = TB_W'(CODE_BITS - 1);
    localparam logic [TB_W-1:0] TB_ONE = 1;

    logic [TB_W-1:0]       trialBit_q, trialBit_d;
    logic [CODE_BITS-1:0]  sarCode;

    // Successive-approximation step for the current trial bit. A higher code
    // lowers the count, so a count still above target means the code may stay
    // this high and the trial bit is kept; otherwise it is dropped. The next
    // lower bit is then set as the new trial.
    always_comb begin
        sarCode = code_q;
        if (!(count_i > target_i)) begin
            sarCode[trialBit_q] = 1'b0;
        end
        if (trialBit_q != '0) begin
            sarCode[trialBit_q - TB_ONE] = 1'b1;
        end
    end
`endif

    // Tracking arithmetic. The error is count minus target in one extra bit so
    // it can go negative. The step grows with the error magnitude so large
    // excursions are pulled in quickly while small ones move one LSB at a time.
    // Sums are formed in a wider word so clamping at full scale and at zero
    // never wraps.
    always_comb begin
        err      = $signed({1'b0, count_i}) - $signed({1'b0, target_i});
        dbSigned = $signed({1'b0, deadband_i});
        errMag   = err[COUNT_BITS] ? $unsigned(-err) : $unsigned(err);
        step     = (errMag >> STEP_SHIFT) + ONE_STEP;
        codeExt  = SW'(code_q);
        stepExt  = SW'(step);
        codeUp   = codeExt + stepExt;
        codeDown = codeExt - stepExt;
        trkUp    = (codeUp > SW'(MAX_CODE)) ? MAX_CODE : codeUp[CODE_BITS-1:0];
        trkDown  = (stepExt > codeExt) ? '0 : codeDown[CODE_BITS-1:0];
        overBand  = (err > dbSigned);
        underBand = (err < -dbSigned);
    end

    // Next-state and next-output logic. Priority is enable (forces IDLE),
    // then start (restart acquisition from mid-scale), then the normal
    // settle/evaluate sequence. The sample handshake is resolved at the end so
    // a pending sample can still drain while the sequencer is idle or
    // restarting.
    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        code_d        = code_q;
        lockCnt_d     = lockCnt_q;
        locked_d      = locked_q;
        overrun_d     = overrun_q;
        sampleValid_d = sampleValid_q;
        sampleCode_d  = sampleCode_q;
        evalFire      = 1'b0;
        sampleLoad    = 1'b0;
`ifdef SERVO_SAR_EN
        trialBit_d    = trialBit_q;
`endif

        if (!enable_i) begin
            state_d   = IDLE;
            lockCnt_d = '0;
            locked_d  = 1'b0;
        end else if (start_i) begin
            code_d    = MID_CODE;
            settle_d  = SETTLE_RELOAD;
            lockCnt_d = '0;
            locked_d  = 1'b0;
            overrun_d = 1'b0;
`ifdef SERVO_SAR_EN
            trialBit_d = TB_MSB;
            state_d    = SAR_SETTLE;
`else
            state_d    = TRK_SETTLE;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
`ifdef SERVO_SAR_EN
                SAR_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = SAR_EVAL;
                    end else begin
                        settle_d = settle_q - SC_ONE;
                    end
                end
                SAR_EVAL: begin
                    evalFire = 1'b1;
                    settle_d = SETTLE_RELOAD;
                    code_d   = sarCode;
                    if (trialBit_q != '0) begin
                        trialBit_d = trialBit_q - TB_ONE;
                        state_d    = SAR_SETTLE;
                    end else begin
                        state_d    = TRK_SETTLE;
                    end
                end
`endif
                TRK_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = TRK_EVAL;
                    end else begin
                        settle_d = settle_q - SC_ONE;
                    end
                end
                TRK_EVAL: begin
                    evalFire = 1'b1;
                    settle_d = SETTLE_RELOAD;
                    state_d  = TRK_SETTLE;
                    if (overBand) begin
                        code_d    = trkUp;
                        lockCnt_d = '0;
                        locked_d  = 1'b0;
                    end else if (underBand) begin
                        code_d    = trkDown;
                        lockCnt_d = '0;
                        locked_d  = 1'b0;
                    end else begin
                        if (lockCnt_q < LOCK_MAX) begin
                            lockCnt_d = lockCnt_q + LC_ONE;
                        end
                        locked_d = (lockCnt_d >= LOCK_MAX);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A new sample may only replace the register when it is empty or
        // being drained this very cycle; otherwise the oldest sample is kept
        // and the drop is flagged.
        sampleLoad = !sampleValid_q || sample_if.sample_ready;
        if (evalFire) begin
            if (sampleLoad) begin
                sampleValid_d = 1'b1;
                sampleCode_d  = code_q;
            end else begin
                overrun_d     = 1'b1;
            end
        end else if (sampleValid_q && sample_if.sample_ready) begin
            sampleValid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset. Reset parks the DAC
    // at mid-scale so the comparator starts from a neutral threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            settle_q      <= '0;
            code_q        <= MID_CODE;
            lockCnt_q     <= '0;
            locked_q      <= 1'b0;
            overrun_q     <= 1'b0;
            sampleValid_q <= 1'b0;
            sampleCode_q  <= '0;
`ifdef SERVO_SAR_EN
            trialBit_q    <= TB_MSB;
`endif
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            code_q        <= code_d;
            lockCnt_q     <= lockCnt_d;
            locked_q      <= locked_d;
            overrun_q     <= overrun_d;
            sampleValid_q <= sampleValid_d;
            sampleCode_q  <= sampleCode_d;
`ifdef SERVO_SAR_EN
            trialBit_q    <= trialBit_d;
`endif
        end
    end

    assign dac_code_o             = code_q;
    assign sample_if.sample_valid = sampleValid_q;
    assign sample_if.sample_code  = sampleCode_q;
    assign overrun_o              = overrun_q;
    assign locked_o               = locked_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_threshold_servo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_threshold_servo_ctrl
//
// Drives threshold_servo_ctrl with a simple plant (count = K - code, clamped,
// or a fixed count) and compares every cycle against a behavioural model that
// works in terms of "cycles since start" and evaluation events.
// ----------------------------------------------------------------------------
module tb_threshold_servo_ctrl;

    localparam int CODE_BITS  = 10;
    localparam int COUNT_BITS = 10;
    localparam int SETTLE     = 8;
    localparam int STEP_SHIFT = 4;
    localparam int LOCK_COUNT = 4;
    localparam int CODE_MAX   = 1023;
    localparam int MID        = 512;

`ifdef SERVO_SAR_EN
    localparam bit SAR_BUILD = 1'b1;
`else
    localparam bit SAR_BUILD = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic                   start;
    logic [COUNT_BITS-1:0]  target;
    logic [COUNT_BITS-1:0]  deadband;
    logic [COUNT_BITS-1:0]  countIn;
    logic [CODE_BITS-1:0]   dacCode;
    logic                   overrun;
    logic                   locked;
    logic [2:0]             state;

    threshold_servo_ctrl_if #(.CODE_BITS(CODE_BITS)) smpIf ();

    threshold_servo_ctrl #(
        .CODE_BITS     (CODE_BITS),
        .COUNT_BITS    (COUNT_BITS),
        .SETTLE_CYCLES (SETTLE),
        .STEP_SHIFT    (STEP_SHIFT),
        .LOCK_COUNT    (LOCK_COUNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable),
        .start_i    (start),
        .target_i   (target),
        .deadband_i (deadband),
        .count_i    (countIn),
        .dac_code_o (dacCode),
        .sample_if  (smpIf),
        .overrun_o  (overrun),
        .locked_o   (locked),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    // Plant: window count falls as the code rises, or is pinned to a value.
    int plantK    = 1023;
    bit fixedMode = 1'b0;
    int fixedVal  = 0;

    function automatic int plantCount(int k, bit fm, int fv, int code);
        int v;
        if (fm) return fv;
        v = k - code;
        if (v < 0)    v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    always @* countIn = 10'(plantCount(plantK, fixedMode, fixedVal, int'(dacCode)));

    // Behavioural model state. mMode: 0 idle, 1 acquiring, 2 tracking.
    // mPhase counts cycles since the last code change; phase SETTLE is the
    // evaluation cycle.
    int mCode, mMode, mPhase, mBit, mInband, mSample;
    bit mLocked, mValid, mOverrun;

    int checkCount = 0;
    int failCount  = 0;
    bit sawSarState = 1'b0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int expState();
        if (mMode == 0) return 0;
        if (mPhase == SETTLE) return (mMode == 1) ? 2 : 4;
        return (mMode == 1) ? 1 : 3;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        int cnt, err, stp, evalCode;
        bit evalNow;
        evalNow  = 1'b0;
        evalCode = 0;
        if (rst) begin
            mCode = MID; mMode = 0; mPhase = 0; mBit = CODE_BITS - 1; mInband = 0;
            mLocked = 0; mValid = 0; mOverrun = 0; mSample = 0;
            return;
        end
        if (!enable) begin
            mMode = 0; mLocked = 0; mInband = 0;
        end else if (start) begin
            mCode = MID; mPhase = 0; mInband = 0; mLocked = 0; mOverrun = 0;
            mBit = CODE_BITS - 1;
            mMode = SAR_BUILD ? 1 : 2;
        end else if (mMode != 0) begin
            if (mPhase < SETTLE) begin
                mPhase++;
            end else begin
                evalNow  = 1'b1;
                evalCode = mCode;
                mPhase   = 0;
                cnt = plantCount(plantK, fixedMode, fixedVal, mCode);
                if (mMode == 1) begin
                    if (!(cnt > int'(target))) mCode = mCode & ~(1 << mBit);
                    if (mBit > 0) begin
                        mBit--;
                        mCode = mCode | (1 << mBit);
                    end else begin
                        mMode = 2;
                    end
                end else begin
                    err = cnt - int'(target);
                    stp = 1 + ((err < 0 ? -err : err) / 16);
                    if (err > int'(deadband)) begin
                        mCode = (mCode + stp > CODE_MAX) ? CODE_MAX : mCode + stp;
                        mInband = 0; mLocked = 0;
                    end else if (err < -int'(deadband)) begin
                        mCode = (mCode - stp < 0) ? 0 : mCode - stp;
                        mInband = 0; mLocked = 0;
                    end else begin
                        mInband++;
                        mLocked = (mInband >= LOCK_COUNT);
                    end
                end
            end
        end
        if (evalNow) begin
            if (!mValid || smpIf.sample_ready) begin
                mValid  = 1'b1;
                mSample = evalCode;
            end else begin
                mOverrun = 1'b1;
            end
        end else if (mValid && smpIf.sample_ready) begin
            mValid = 1'b0;
        end
    endtask

    task automatic checkAll();
        if (state == 3'd1 || state == 3'd2) sawSarState = 1'b1;
        checkOutput("dac_code",     int'(dacCode),            mCode);
        checkOutput("state",        int'(state),              expState());
        checkOutput("locked",       int'(locked),             int'(mLocked));
        checkOutput("sample_valid", int'(smpIf.sample_valid), int'(mValid));
        checkOutput("sample_code",  int'(smpIf.sample_code),  mSample);
        checkOutput("overrun",      int'(overrun),            int'(mOverrun));
    endtask

    // Run n clocks: model and DUT see the same inputs, outputs checked #1
    // after each rising edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            modelStep();
            @(posedge clk);
            #1;
            checkAll();
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
    endtask

    int lossBase;
    int segLen;

    initial begin
        rst = 1'b1; enable = 1'b0; start = 1'b0;
        target = 10'd850; deadband = 10'd2;
        smpIf.sample_ready = 1'b1;
        mCode = MID; mMode = 0; mPhase = 0; mBit = CODE_BITS - 1; mInband = 0;
        mLocked = 0; mValid = 0; mOverrun = 0; mSample = 0;

        $display("[TB] reset");
        applyStimulus(3);
        checkOutput("reset_code",  int'(dacCode), 512);
        checkOutput("reset_state", int'(state),   0);
        rst = 1'b0;
        enable = 1'b1;
        applyStimulus(2);

        $display("[TB] acquisition target=850 deadband=2 plant=1023-code");
        pulseStart();
`ifdef SERVO_SAR_EN
        checkOutput("start_state", int'(state), 1);
        applyStimulus(10 * (SETTLE + 1));
        checkOutput("sar_final_code", int'(dacCode), 172);
        checkOutput("sar_to_trk",     int'(state),   3);
        applyStimulus(3 * (SETTLE + 1));
        checkOutput("trk_hold_code",  int'(dacCode), 172);
        checkOutput("not_yet_locked", int'(locked),  0);
        applyStimulus(SETTLE + 1);
        checkOutput("locked_after_4", int'(locked),  1);
`else
        checkOutput("start_state", int'(state),   3);
        checkOutput("start_code",  int'(dacCode), 512);
        applyStimulus(80 * (SETTLE + 1));
        checkOutput("trk_converged", int'(dacCode >= 10'd171 && dacCode <= 10'd175), 1);
        checkOutput("trk_locked",    int'(locked), 1);
        checkOutput("no_sar_states", int'(sawSarState), 0);
`endif

        $display("[TB] lock loss with err=+40");
        lossBase = mCode;
        plantK = 890 + mCode;
        applyStimulus(SETTLE + 1);
        checkOutput("loss_locked", int'(locked),  0);
        checkOutput("loss_code",   int'(dacCode), lossBase + 3);

        $display("[TB] restart mid-track");
        applyStimulus(4);
        pulseStart();
        checkOutput("restart_state", int'(state),   SAR_BUILD ? 1 : 3);
        checkOutput("restart_code",  int'(dacCode), 512);

        $display("[TB] enable low");
        applyStimulus(5);
        enable = 1'b0;
        applyStimulus(1);
        checkOutput("disable_state", int'(state),   0);
        checkOutput("disable_code",  int'(dacCode), 512);
        applyStimulus(3);
        enable = 1'b1;

        $display("[TB] saturation high then low");
        plantK = 1023; fixedMode = 1'b1; fixedVal = 1023;
        target = 10'd512; deadband = 10'd0;
        pulseStart();
`ifndef SERVO_SAR_EN
        applyStimulus(SETTLE + 1);
        checkOutput("sat_first_step", int'(dacCode), 544);
        applyStimulus(29 * (SETTLE + 1));
`else
        applyStimulus(30 * (SETTLE + 1));
`endif
        checkOutput("sat_high", int'(dacCode), 1023);
        fixedVal = 0;
        applyStimulus(40 * (SETTLE + 1));
        checkOutput("sat_low", int'(dacCode), 0);

        $display("[TB] reset during track settle");
        applyStimulus(3);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("rst_mid_code",   int'(dacCode), 512);
        checkOutput("rst_mid_state",  int'(state),   0);
        checkOutput("rst_mid_locked", int'(locked),  0);
        rst = 1'b0;

        $display("[TB] backpressure");
        fixedMode = 1'b0; plantK = 1023; target = 10'd850; deadband = 10'd2;
        smpIf.sample_ready = 1'b1;
        enable = 1'b0;
        applyStimulus(2);
        enable = 1'b1;
        pulseStart();
        smpIf.sample_ready = 1'b0;
        applyStimulus(SETTLE + 1);
        checkOutput("bp_valid_1",   int'(smpIf.sample_valid), 1);
        checkOutput("bp_overrun_1", int'(overrun), 0);
        applyStimulus(SETTLE + 1);
        checkOutput("bp_valid_2",   int'(smpIf.sample_valid), 1);
        checkOutput("bp_code",      int'(smpIf.sample_code),  512);
        checkOutput("bp_overrun_2", int'(overrun), 1);
        smpIf.sample_ready = 1'b1;
        applyStimulus(3);
        checkOutput("bp_overrun_sticky", int'(overrun), 1);
        pulseStart();
        checkOutput("bp_overrun_clear", int'(overrun), 0);

        $display("[TB] randomized segments");
        for (int seg = 0; seg < 40; seg++) begin
            target   = 10'($urandom_range(100, 1000));
            deadband = 10'($urandom_range(0, 40));
            plantK   = int'($urandom_range(200, 1800));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                applyStimulus(1);
                rst = 1'b0;
            end
            if ($urandom_range(0, 2) == 0 || seg == 0) begin
                pulseStart();
            end
            segLen = int'($urandom_range(50, 200));
            for (int c = 0; c < segLen; c++) begin
                smpIf.sample_ready = ($urandom_range(0, 3) != 0);
                enable = ($urandom_range(0, 63) != 0);
                start  = ($urandom_range(0, 127) == 0);
                applyStimulus(1);
            end
            start  = 1'b0;
            enable = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/threshold_servo_ctrl.md
Name: threshold_servo_ctrl

Overview:
- Sequencer for the comparator threshold loop, which is the chain of threshold DAC, LVDS comparator and window counter.
- Drives the DAC code and waits a settle interval after every code change so the window count reflects the new code.
- Acquires the operating point by successive approximation, then tracks it with a deadband servo.
- Publishes each evaluated code over a valid/ready handshake and raises `locked` once the loop is stable.

Parameters:
- CODE_BITS, 10, width of the DAC code.
- COUNT_BITS, 10, width of the window count input.
- SETTLE_CYCLES, 2048, clocks waited after any code change before sampling `count_in`. Must be at least the window length plus 2.
- STEP_SHIFT, 4, track step is `1 + (|err| >> STEP_SHIFT)`.
- LOCK_COUNT, 4, consecutive in-deadband evaluations needed to assert `locked`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  low forces IDLE, checked every cycle.
- start  in  1  one-cycle pulse; begins or restarts acquisition.
- target  in  COUNT_BITS  desired window count.
- deadband  in  COUNT_BITS  allowed |count − target| while tracking.
- count_in  in  COUNT_BITS  window count from the window counter.
- dac_code  out  CODE_BITS  registered code to the DAC.
- sample_valid  out  1  evaluated sample pending.
- sample_ready  in  1  consumer accepts the sample.
- sample_code  out  CODE_BITS  code that was evaluated.
- overrun  out  1  sticky; a sample was dropped.
- locked  out  1  loop settled within the deadband.
- state  out  3  current state encoding, for debug and LEDs.

Behaviour:
- **States:** IDLE=0, SAR_SETTLE=1, SAR_EVAL=2, TRK_SETTLE=3, TRK_EVAL=4.
- **Reset values:** `dac_code` = 1<<(CODE_BITS−1); `sample_valid`, `overrun`, `locked` = 0; `sample_code` = 0; state = IDLE.
- **Outputs and inputs:** all outputs are registered. `target` and `deadband` are sampled at each EVAL.
- **Settle timer:**
  - Loads SETTLE_CYCLES−1 on entry to any SETTLE state and decrements to 0.
  - The following cycle is the EVAL state, which lasts exactly 1 cycle.
  - `dac_code` updates on the clock edge that leaves EVAL.
- **IDLE:**
  - Holds `dac_code`.
  - On `start` with `enable` high: set `dac_code` to mid-scale (trial bit = MSB), clear `overrun` and `locked`, go to SAR_SETTLE.
- **SAR_EVAL (trial bit b):**
  - A higher code lowers the count.
  - If `count_in > target`, keep bit b; else clear it.
  - If b > 0, set bit b−1 and go to SAR_SETTLE.
  - If b = 0, go to TRK_SETTLE with the final code.
  - Acquisition takes exactly CODE_BITS evaluations.
- **TRK_EVAL:** compute err = count_in − target, signed, COUNT_BITS+1 bits.
  - err > deadband: code += step, saturating at 2^CODE_BITS−1.
  - err < −deadband: code −= step, saturating at 0.
  - Otherwise: code is unchanged and the lock counter increments (saturating).
  - Any out-of-band evaluation clears the lock counter and deasserts `locked`.
  - `locked` = 1 while the lock counter ≥ LOCK_COUNT.
  - Always return to TRK_SETTLE.
- **Sample handshake:**
  - Every EVAL (SAR and TRK) produces a sample with `sample_code` = code being evaluated.
  - If `sample_valid` is 0, or `sample_ready` is high that cycle, load the new sample and set `sample_valid`.
  - Otherwise keep the oldest sample and set `overrun`.
  - A transfer happens on any cycle where `sample_valid && sample_ready`; `sample_valid` clears unless a new sample loads in the same cycle.
- **`start` while busy:** restarts acquisition immediately; the settle timer reloads and `locked` clears.
- **`enable` low:** next state is IDLE; `dac_code` holds; `locked` clears.
- **`rst` mid-operation:** all outputs return to reset values on the next edge.

Optional Feature:
- Macro: `SERVO_SAR_EN`.
- **Defined:** SAR acquisition as above.
- **Undefined:**
  - SAR states are removed.
  - `start` sets `dac_code` to mid-scale and goes directly to TRK_SETTLE.
  - Lock is reached by track stepping only.
  - State encodings 1 and 2 never appear.

Test Plan:
- **SAR acquisition.**
  - Stimulus: `SERVO_SAR_EN` defined, SETTLE_CYCLES=8, bench model count = 1023 − code, target=850, deadband=2, `start`.
  - Response: 10 SAR samples; final code 172; first TRK evaluation leaves code at 172; `locked` rises after 4 TRK evaluations.
- **Saturation.**
  - Stimulus: `count_in` fixed at 1023, target=512, deadband=0.
  - Response: code steps by 32 each TRK_EVAL, clamps at 1023 and holds; with `count_in` fixed at 0 it clamps at 0 and never wraps.
- **Backpressure.**
  - Stimulus: `sample_ready` held low across 2 evaluations.
  - Response: `sample_valid` = 1; `sample_code` = first evaluated code; `overrun` sets at the second EVAL and persists until `start`.
- **Reset and enable mid-settle.**
  - Stimulus: `rst` pulsed during TRK_SETTLE.
  - Response: next cycle `dac_code` = 512, state = 0, `locked` = 0.
  - Stimulus: `enable` low.
  - Response: state = 0, code held.
- **Lock loss and restart.**
  - Stimulus: step the model offset so err = +40 after lock.
  - Response: `locked` drops on that EVAL; code += 3.
  - Stimulus: `start` mid-track.
  - Response: state = 1, code = 512.
- **Build without the macro.**
  - Stimulus: `SERVO_SAR_EN` undefined, same model as the SAR acquisition test.
  - Response: `start` goes straight to state 3; code reaches 172 ± 2 via track steps; state never equals 1 or 2.
